// File: rtl/ber_sweep_seq.sv
// ber_sweep_seq: steps MAIN_MODE from FIRST_MODE to LAST_MODE. For each mode
// it holds CLR for SETTLE_CYC cycles, releases CLR for a DWELL window,
// captures the stimulus block's counters, and hands the result out over a
// valid/ready port. Error counts accumulate into a saturating sweep total.
module ber_sweep_seq #(
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        ABORT,
  input  logic [7:0]  FIRST_MODE,
  input  logic [7:0]  LAST_MODE,
  input  logic [7:0]  SUB_MODE_IN,
  input  logic [31:0] DWELL,
  output logic [7:0]  MAIN_MODE,
  output logic [7:0]  SUB_MODE,
  output logic        CLR,
  input  logic [57:0] RECV_CNT,
  input  logic [63:0] ERR_CNT,
  output logic        RES_VALID,
  input  logic        RES_READY,
  output logic [7:0]  RES_MODE,
  output logic [57:0] RES_RECV,
  output logic [63:0] RES_ERR,
  output logic        BUSY,
  output logic        DONE,
  output logic        CFG_ERR,
  output logic [63:0] TOTAL_ERR
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_DWELL   = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_OUTPUT  = 3'd4;

  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYC - 1);

  logic [2:0]  r_state;
  logic [7:0]  r_cur;
  logic [7:0]  r_last;
  logic [7:0]  r_sub;
  logic [31:0] r_dwell_last;
  logic [31:0] r_cnt;
  logic [7:0]  r_res_mode;
  logic [57:0] r_res_recv;
  logic [63:0] r_res_err;
  logic [63:0] r_total;
  logic        r_done;
  logic        r_cfg_err;

  logic        w_cfg_bad;
  logic [64:0] w_sum;
  logic [63:0] w_total_sat;

  // A sweep that would end on 255 or run backwards is rejected; this also
  // guarantees the mode increment never wraps.
  assign w_cfg_bad   = (FIRST_MODE > LAST_MODE) || (LAST_MODE == 8'd255);
  assign w_sum       = {1'b0, r_total} + {1'b0, ERR_CNT};
  assign w_total_sat = w_sum[64] ? '1 : w_sum[63:0];

  // Sweep sequencer: config latch, per-mode phase timing, result capture.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= S_IDLE;
      r_cur        <= '0;
      r_last       <= '0;
      r_sub        <= '0;
      r_dwell_last <= '0;
      r_cnt        <= '0;
      r_res_mode   <= '0;
      r_res_recv   <= '0;
      r_res_err    <= '0;
      r_total      <= '0;
      r_done       <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Abort beats everything else once a sweep is running; results and
      // the running total are left as they were.
      if (ABORT && (r_state != S_IDLE)) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (START && !ABORT) begin
              r_cfg_err    <= w_cfg_bad;
              r_total      <= '0;
              r_cur        <= FIRST_MODE;
              r_last       <= LAST_MODE;
              r_sub        <= SUB_MODE_IN;
              r_dwell_last <= (DWELL == 32'd0) ? 32'd0 : DWELL - 32'd1;
              r_cnt        <= '0;
              if (w_cfg_bad) begin
                r_done <= 1'b1;
              end else begin
                r_state <= S_CLEAR;
              end
            end
          end
          S_CLEAR: begin
            if (r_cnt == SETTLE_LAST) begin
              r_cnt   <= '0;
              r_state <= S_DWELL;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
          S_DWELL: begin
            if (r_cnt == r_dwell_last) begin
              r_cnt   <= '0;
              r_state <= S_CAPTURE;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
          S_CAPTURE: begin
            r_res_mode <= r_cur;
            r_res_recv <= RECV_CNT;
            r_res_err  <= ERR_CNT;
            r_total    <= w_total_sat;
            r_state    <= S_OUTPUT;
          end
          S_OUTPUT: begin
            if (RES_READY) begin
              if (r_cur == r_last) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end else begin
                r_cur   <= r_cur + 8'd1;
                r_state <= S_CLEAR;
              end
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Stimulus-side outputs decode straight from state so reset takes effect
  // on them without waiting for a clock.
  assign MAIN_MODE = (r_state == S_IDLE) ? 8'd255 : r_cur;
  assign SUB_MODE  = (r_state == S_IDLE) ? 8'd0   : r_sub;
  assign CLR       = (r_state == S_IDLE) || (r_state == S_CLEAR);
  assign BUSY      = (r_state != S_IDLE);
  assign RES_VALID = (r_state == S_OUTPUT);
  assign RES_MODE  = r_res_mode;
  assign RES_RECV  = r_res_recv;
  assign RES_ERR   = r_res_err;
  assign DONE      = r_done;
  assign CFG_ERR   = r_cfg_err;
  assign TOTAL_ERR = r_total;

endmodule
